// File: rtl/iter_comparator.sv
// rtl/iter_comparator.sv - multi-cycle MSB-first magnitude comparator, CHUNK bits per cycle.
// Optional early exit on first differing chunk: define ITER_CMP_EARLY_EXIT_EN.
module iter_comparator #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             gt,
  output logic             eq,
  output logic             lt,
  output logic             busy
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = $clog2(N + 1);
  localparam logic [WIDTH-1:0] SIGN = WIDTH'(1) << (WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  generate
    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
      $error("iter_comparator: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  logic [1:0]       state;
  logic [WIDTH-1:0] sh_a, sh_b;
  logic [CW-1:0]    cnt;
  logic             diff;
  logic [CHUNK-1:0] ca, cb;
  logic             chunk_ne, last, finish;

  assign ca       = sh_a[WIDTH-1 -: CHUNK];
  assign cb       = sh_b[WIDTH-1 -: CHUNK];
  assign chunk_ne = (ca != cb);
  assign last     = (cnt == CW'(1));
  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

`ifdef ITER_CMP_EARLY_EXIT_EN
  assign finish = last || chunk_ne;
`else
  assign finish = last;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sh_a      <= '0;
      sh_b      <= '0;
      cnt       <= '0;
      diff      <= 1'b0;
      out_valid <= 1'b0;
      gt        <= 1'b0;
      eq        <= 1'b0;
      lt        <= 1'b0;
    end else if (abort) begin
      if (state != IDLE) begin
        state     <= IDLE;
        out_valid <= 1'b0;
        gt        <= 1'b0;
        eq        <= 1'b0;
        lt        <= 1'b0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Offset-binary: flipping the sign bit turns a signed compare into an unsigned one.
            sh_a  <= signed_mode ? (a ^ SIGN) : a;
            sh_b  <= signed_mode ? (b ^ SIGN) : b;
            cnt   <= CW'(N);
            diff  <= 1'b0;
            gt    <= 1'b0;
            eq    <= 1'b0;
            lt    <= 1'b0;
            state <= RUN;
          end
        end
        RUN: begin
          // Only the first (most significant) differing chunk decides the result.
          if (!diff && chunk_ne) begin
            gt   <= (ca > cb);
            lt   <= (ca < cb);
            diff <= 1'b1;
          end
          sh_a <= sh_a << CHUNK;
          sh_b <= sh_b << CHUNK;
          cnt  <= cnt - CW'(1);
          if (finish) begin
            state     <= DONE;
            out_valid <= 1'b1;
            eq        <= !diff && !chunk_ne;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
